pd_nios2_gen2_0_cpu_mult_combine: RTL and testbench

//  Consumer end of the 16x16 multiplier cell: takes the registered partial products
//  (p1=alo*blo, p2=alo*bhi, p3=ahi*blo, optional p4=ahi*bhi) and assembles the
//  32-bit MUL result, or the MULXUU high word when that option is built.
//  Two-stage valid/ready pipeline between the mult cell outputs and the W-stage result mux.

---
 rtl/pd_nios2_gen2_0_cpu_mult_combine_if.sv | 52 +++++
 rtl/pd_nios2_gen2_0_cpu_mult_combine.sv | 114 +++++++++++
 tb/tb_pd_nios2_gen2_0_cpu_mult_combine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_nios2_gen2_0_cpu_mult_combine_if.sv
// Bus between the 16x16 multiplier cell, the product combiner and the W-stage result mux.
// Carries the pipeline kill, the partial-product input handshake and the result handshake.
interface pd_nios2_gen2_0_cpu_mult_combine_if #(
  parameter int unsigned WIDTH = 32
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p1;
  logic [WIDTH-1:0] in_p2;
  logic [WIDTH-1:0] in_p3;
  logic [WIDTH-1:0] in_p4;
  logic             in_hi_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_hi;

  // Producer/consumer side: drives the partial products and the result ready.
  modport master (
    output flush,
    output in_valid,
    output in_p1,
    output in_p2,
    output in_p3,
    output in_p4,
    output in_hi_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_hi
  );

  // Combiner side.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_p1,
    input  in_p2,
    input  in_p3,
    input  in_p4,
    input  in_hi_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_hi
  );

endinterface

// File: rtl/pd_nios2_gen2_0_cpu_mult_combine.sv
// Multiplier partial-product combiner: two-stage valid/ready pipeline that sums
// p1 + (p2+p3)<<HALF (+ p4<<WIDTH) and returns the low word (MUL) or, when built
// with NIOS_MULT_COMBINE_MULX_EN, optionally the high word (MULXUU).
// Stage 1 registers p1 and the middle sum p2+p3 with its carry; stage 2 folds them.
module pd_nios2_gen2_0_cpu_mult_combine #(
  parameter int unsigned WIDTH = 32
) (
  input logic                               clk,
  input logic                               reset_n,
  pd_nios2_gen2_0_cpu_mult_combine_if.slave bus
);

  localparam int unsigned HALF = WIDTH / 2;

  logic             s2_adv;
  logic             accept;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p1;
  logic [WIDTH:0]   s1_mid;
  logic [WIDTH:0]   lo_sum;
  logic [WIDTH-1:0] low_word;
  logic [WIDTH-1:0] next_result;

  // Output stage moves when empty or being drained; flush blocks new input.
  assign s2_adv       = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = ~bus.flush & (~s1_valid | s2_adv);
  assign accept       = bus.in_valid & bus.in_ready;

  // Low word: p1 plus the low half of the middle sum shifted up; bit WIDTH is the carry.
  assign lo_sum   = {1'b0, s1_p1} + {1'b0, s1_mid[HALF-1:0], {HALF{1'b0}}};
  assign low_word = lo_sum[WIDTH-1:0];

  // Stage 1 occupancy: flush empties it, accept fills it, a drain without refill empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 1 data: keep p1 and the full-width middle sum including its carry out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_p1  <= '0;
      s1_mid <= '0;
    end else if (accept) begin
      s1_p1  <= bus.in_p1;
      s1_mid <= {1'b0, bus.in_p2} + {1'b0, bus.in_p3};
    end
  end

`ifdef NIOS_MULT_COMBINE_MULX_EN
  logic [WIDTH-1:0] s1_p4;
  logic             s1_hi;
  logic [WIDTH-1:0] high_word;

  // High word: p4 plus the upper middle sum plus the carry out of the low word.
  assign high_word   = s1_p4 + WIDTH'(s1_mid[WIDTH:HALF]) + WIDTH'(lo_sum[WIDTH]);
  assign next_result = s1_hi ? high_word : low_word;

  // Stage 1 high-path data: p4 and the word select travel with the operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_p4 <= '0;
      s1_hi <= 1'b0;
    end else if (accept) begin
      s1_p4 <= bus.in_p4;
      s1_hi <= bus.in_hi_sel;
    end
  end

  // Stage 2 word-select flag, updated alongside the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_hi <= 1'b0;
    end else if (!bus.flush && s2_adv) begin
      bus.out_hi <= s1_hi;
    end
  end
`else
  logic unused_bits;

  // Only the low word exists; the high-path inputs and carries are not consumed.
  assign next_result = low_word;
  assign bus.out_hi  = 1'b0;
  assign unused_bits = ^{lo_sum[WIDTH], s1_mid[WIDTH:HALF], bus.in_p4, bus.in_hi_sel};
`endif

  // Stage 2 valid: flush wins, otherwise take stage 1 occupancy when advancing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
    end
  end

  // Stage 2 result: held while stalled; left untouched by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_result <= '0;
    end else if (!bus.flush && s2_adv) begin
      bus.out_result <= next_result;
    end
  end

endmodule

// File: tb/tb_pd_nios2_gen2_0_cpu_mult_combine.sv
// Bench for pd_nios2_gen2_0_cpu_mult_combine: directed cases with literal
// expectations plus randomized traffic against an in-order queue model that
// computes results from the full 66-bit sum of the partial products.
// Honours NIOS_MULT_COMBINE_MULX_EN the same way as the design.
module tb_pd_nios2_gen2_0_cpu_mult_combine;

  localparam int unsigned WIDTH = 32;
`ifdef NIOS_MULT_COMBINE_MULX_EN
  localparam bit MULX = 1'b1;
`else
  localparam bit MULX = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  pd_nios2_gen2_0_cpu_mult_combine_if #(.WIDTH(WIDTH)) bus ();

  pd_nios2_gen2_0_cpu_mult_combine #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        hi;
    int          age;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result is a slice of the exact sum p1 + (p2+p3)*2^16 + p4*2^32.
  function automatic exp_t model(input logic [31:0] p1, input logic [31:0] p2,
                                 input logic [31:0] p3, input logic [31:0] p4,
                                 input logic hs);
    logic [65:0] full;
    exp_t        e;
    full  = 66'(p1) + ((66'(p2) + 66'(p3)) << 16) + (66'(p4) << 32);
    e.hi  = MULX & hs;
    e.res = e.hi ? full[63:32] : full[31:0];
    e.age = 0;
    return e;
  endfunction

  // Per-cycle compare against the in-flight queue, sampled mid-cycle.
  logic exp_ov;
  logic exp_rdy;
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_result", bus.out_result, 32'h0);
      chk("rst_out_hi", 32'(bus.out_hi), 32'h0);
    end else begin
      exp_rdy = !bus.flush && (q.size() < 2 || bus.out_ready);
      exp_ov  = (q.size() > 0) && (q[0].age >= 2);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov && bus.out_valid) begin
        chk("out_result", bus.out_result, q[0].res);
        chk("out_hi", 32'(bus.out_hi), 32'(q[0].hi));
      end
      if (exp_ov && bus.out_ready) void'(q.pop_front());
      if (bus.flush) q.delete();
      else if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_p1, bus.in_p2, bus.in_p3, bus.in_p4, bus.in_hi_sel));
      foreach (q[i]) q[i].age++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                        input logic [31:0] p4, input logic hs);
    bus.in_p1     = p1;
    bus.in_p2     = p2;
    bus.in_p3     = p3;
    bus.in_p4     = p4;
    bus.in_hi_sel = hs;
  endtask

  // Half the time real 16x16 partial products of random operands, else raw words.
  task automatic rand_op();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    if ($urandom_range(1, 0) == 1)
      set_op(32'(a[15:0]) * 32'(b[15:0]), 32'(a[15:0]) * 32'(b[31:16]),
             32'(a[31:16]) * 32'(b[15:0]), 32'(a[31:16]) * 32'(b[31:16]),
             1'($urandom_range(1, 0)));
    else
      set_op($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(1, 0)));
  endtask

  // Single op into an empty pipe with out_ready=1; result expected two edges after accept.
  task automatic one_op(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                        input logic [31:0] p4, input logic hs, input logic [31:0] er,
                        input logic eh, input string name);
    set_op(p1, p2, p3, p4, hs);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'h1);
    chk(name, bus.out_result, er);
    chk({name, "_hi"}, 32'(bus.out_hi), 32'(eh));
    tick();
  endtask

  int acc;
  int nv;
  int first;
  int last;
  logic took;

  initial begin
    reset_n       = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Small operands, low and high word.
    one_op(32'd8, 32'd10, 32'd12, 32'd15, 1'b0, 32'h00160008, 1'b0, "t1_lo");
    one_op(32'd8, 32'd10, 32'd12, 32'd15, 1'b1,
           MULX ? 32'h0000000F : 32'h00160008, MULX, "t1_hi");

    // All-ones operands exercise the carry into the high word.
    one_op(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b0,
           32'h00000001, 1'b0, "t2_lo");
    one_op(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b1,
           MULX ? 32'hFFFFFFFE : 32'h00000001, MULX, "t2_hi");

    // Eight back-to-back ops give eight consecutive results.
    nv = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rand_op();
          bus.in_valid = 1'b1;
          tick();
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            nv++;
            if (first < 0) first = c;
            last = c;
          end
        end
      end
    join
    tick();
    chk("t3_count", 32'(nv), 32'd8);
    chk("t3_span", 32'(last - first + 1), 32'd8);

    // Downstream stalled for 5 cycles: only two ops get in.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rand_op();
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = bus.in_ready;
      if (took) acc++;
      tick();
      if (took) rand_op();
    end
    chk("t4_accepts", 32'(acc), 32'd2);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();

    // Fill both stages, then flush with an input offered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rand_op();
    acc = 0;
    for (int c = 0; c < 5 && acc < 2; c++) begin
      @(negedge clk);
      took = bus.in_ready;
      if (took) acc++;
      tick();
      if (took) rand_op();
    end
    chk("t5_filled", 32'(acc), 32'd2);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_flush_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_flush_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.out_ready = 1'b1;
    one_op(32'd8, 32'd10, 32'd12, 32'd15, 1'b0, 32'h00160008, 1'b0, "t5_after");

    // Asynchronous reset with ops in flight.
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_op();
      tick();
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_result", bus.out_result, 32'h0);
    chk("t6_hi", 32'(bus.out_hi), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic with stalls and occasional flushes.
    rand_op();
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(3, 0) != 0);
      bus.out_ready = ($urandom_range(3, 0) != 0);
      bus.flush     = ($urandom_range(19, 0) == 0);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) rand_op();
    end
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
